spi_reg_bridge: RTL

Command decoder and register-bus master that consumes 32-bit words from the SPI slave receive port and produces response words on its transmit port. Sits directly downstream of the SPI slave: decodes write/read/NOP headers, runs one register-bus transaction per command with timeout, and returns read data to the slave for shifting out on MISO during the next SPI word.

---
 rtl/spi_reg_bridge.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bridge.sv
// Command decoder and register-bus master between an SPI slave's word ports and a simple req/ack register bus.
// Decodes NOP/WRITE/READ headers, runs one bus transaction per command with a timeout, and returns read data for shifting out.
module spi_reg_bridge #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic [31:0]       rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [31:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic [15:0]       cmd_cnt,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, BUS, RESP} state_t;

  localparam logic [3:0]  OP_NOP   = 4'h0;
  localparam logic [3:0]  OP_WRITE = 4'h1;
  localparam logic [3:0]  OP_READ  = 4'h2;
  // The count seen in the last permitted BUS cycle; req is therefore high exactly TIMEOUT cycles.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              we_nx;
  logic [31:0]       wdata_nx;
  logic [31:0]       tx_data_nx;
  logic [15:0]       tmo_cnt, tmo_nx;
  logic              cs_seen, cs_seen_nx;
  logic              cmd_inc, err_inc;
  logic [3:0]        opcode;
  logic [15:0]       addr_ext;

  assign opcode   = rx_data[31:28];
  assign addr_ext = 16'(bus_addr);

  assign bus_req  = (state == BUS);
  assign tx_valid = (state == RESP);
  assign busy     = (state != IDLE);
  assign rx_ready = (state == IDLE) || (state == WAIT_DATA);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_nx   = state;
    addr_nx    = bus_addr;
    we_nx      = bus_we;
    wdata_nx   = bus_wdata;
    tx_data_nx = tx_data;
    tmo_nx     = tmo_cnt;
    cs_seen_nx = cs_seen;
    cmd_inc    = 1'b0;
    err_inc    = 1'b0;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (opcode)
            OP_NOP: ;
            OP_WRITE: begin
              addr_nx  = rx_data[ADDR_W-1:0];
              state_nx = WAIT_DATA;
            end
            OP_READ: begin
              addr_nx    = rx_data[ADDR_W-1:0];
              we_nx      = 1'b0;
              tmo_nx     = '0;
              cs_seen_nx = 1'b0;
              state_nx   = BUS;
            end
            default: err_inc = 1'b1;
          endcase
        end
      end

      WAIT_DATA: begin
        if (cs_n) begin
          state_nx = IDLE;
        end else if (rx_valid) begin
          wdata_nx   = rx_data;
          we_nx      = 1'b1;
          tmo_nx     = '0;
          cs_seen_nx = 1'b0;
          state_nx   = BUS;
        end
      end

      BUS: begin
        if (rx_valid) err_inc = 1'b1;
        if (cs_n) cs_seen_nx = 1'b1;
        // A deselect during BUS never aborts the access; it only suppresses the read response.
        if (bus_ack) begin
          cmd_inc = 1'b1;
          tmo_nx  = '0;
          if (bus_we) begin
            state_nx = IDLE;
          end else begin
            tx_data_nx = bus_rdata;
            state_nx   = (cs_seen || cs_n) ? IDLE : RESP;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          err_inc = 1'b1;
          tmo_nx  = '0;
          if (bus_we) begin
            state_nx = IDLE;
          end else begin
            tx_data_nx = {16'hDEAD, addr_ext};
            state_nx   = (cs_seen || cs_n) ? IDLE : RESP;
          end
        end else begin
          tmo_nx = tmo_cnt + 16'd1;
        end
      end

      RESP: begin
        if (rx_valid) err_inc = 1'b1;
        if (cs_n || tx_ready) state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_wdata <= '0;
      tx_data   <= '0;
      tmo_cnt   <= '0;
      cs_seen   <= 1'b0;
      cmd_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values, independent of statement order.
      state     <= state_nx;
      bus_addr  <= addr_nx;
      bus_we    <= we_nx;
      bus_wdata <= wdata_nx;
      tx_data   <= tx_data_nx;
      tmo_cnt   <= tmo_nx;
      cs_seen   <= cs_seen_nx;
      if (cmd_inc) cmd_cnt <= cmd_cnt + 16'd1;
      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
